// File: rtl/config_chain_loader.sv
// rtl/config_chain_loader.sv - master for the configuration shift-register chain
//
// Loads config words from a valid/ready write stream into the chain, one shift
// per accepted word, and reads the chain back by rotating it a full N_REG shifts
// while streaming every word out, so the chain contents are preserved.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, mode, abort       command strobe (mode 0=LOAD, 1=READBACK), cancel
//   in_valid/in_ready/in_data     write stream
//   out_valid/out_ready/out_data  readback stream
//   cfg_data_in, cfg_shift_en     drive the chain (only driver of shift_en)
//   cfg_data_out                  last chain word (position N_REG-1)
//   busy, done, word_cnt          status
module config_chain_loader #(
    parameter int CONFIG_L = 32,
    parameter int N_REG    = 405,
    parameter int CNT_L    = $clog2(N_REG + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic                abort,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CONFIG_L-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CONFIG_L-1:0] out_data,
    output logic [CONFIG_L-1:0] cfg_data_in,
    output logic                cfg_shift_en,
    input  logic [CONFIG_L-1:0] cfg_data_out,
    output logic                busy,
    output logic                done,
    output logic [CNT_L-1:0]    word_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READ,
        S_RSHIFT,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [CNT_L-1:0] N_REG_C  = CNT_L'(N_REG);
    localparam logic [CNT_L-1:0] LAST_C   = CNT_L'(N_REG - 1);
    localparam logic [CNT_L-1:0] ONE_C    = CNT_L'(1);

    state_t                state, state_nxt;
    logic [CNT_L-1:0]      cnt_q, cnt_nxt;
    // A LOAD handshake registers the word and a shift request for the next
    // cycle; the final word's shift therefore lands in FLUSH.
    logic                  shift_q, shift_nxt;
    logic [CONFIG_L-1:0]   data_q, data_nxt;
    logic                  in_hs, out_hs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state   <= state_nxt;
            cnt_q   <= cnt_nxt;
            shift_q <= shift_nxt;
            data_q  <= data_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        shift_nxt = 1'b0;
        data_nxt  = data_q;
        in_ready  = (state == S_LOAD) && (cnt_q < N_REG_C);
        out_valid = (state == S_READ);
        // abort wins over a same-cycle handshake, which is then not counted
        in_hs     = in_ready && in_valid && !abort;
        out_hs    = out_valid && out_ready && !abort;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = mode ? S_READ : S_LOAD;
                    cnt_nxt   = '0;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (in_hs) begin
                    shift_nxt = 1'b1;
                    data_nxt  = in_data;
                    cnt_nxt   = cnt_q + ONE_C;
                    if (cnt_q == LAST_C) begin
                        state_nxt = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                state_nxt = abort ? S_IDLE : S_DONE;
            end
            S_READ: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (out_hs) begin
                    cnt_nxt   = cnt_q + ONE_C;
                    state_nxt = S_RSHIFT;
                end
            end
            S_RSHIFT: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = (cnt_q < N_REG_C) ? S_READ : S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // RSHIFT feeds the chain's output back into its input so a full readback
    // pass leaves the chain as it was.
    assign cfg_shift_en = shift_q || (state == S_RSHIFT);
    assign cfg_data_in  = (state == S_RSHIFT) ? cfg_data_out : data_q;
    assign out_data     = (state == S_READ) ? cfg_data_out : '0;
    assign busy         = (state == S_LOAD) || (state == S_READ) ||
                          (state == S_RSHIFT) || (state == S_FLUSH);
    assign done         = (state == S_DONE);
    assign word_cnt     = cnt_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// tb/tb_config_chain_loader.sv - self-checking bench for config_chain_loader
module tb_config_chain_loader;

    localparam int CONFIG_L = 32;
    localparam int N_REG    = 405;
    localparam int CNT_L    = $clog2(N_REG + 1);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                mode = 1'b0;
    logic                abort = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [CONFIG_L-1:0] in_data = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [CONFIG_L-1:0] out_data;
    logic [CONFIG_L-1:0] cfg_data_in;
    logic                cfg_shift_en;
    logic [CONFIG_L-1:0] cfg_data_out;
    logic                busy;
    logic                done;
    logic [CNT_L-1:0]    word_cnt;

    config_chain_loader #(.CONFIG_L(CONFIG_L), .N_REG(N_REG)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_data_in(cfg_data_in), .cfg_shift_en(cfg_shift_en),
        .cfg_data_out(cfg_data_out), .busy(busy), .done(done), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Chain model: word 0 takes data_in, word N_REG-1 drives data_out.
    logic [CONFIG_L-1:0] chain [N_REG];
    always @(posedge clk) begin
        if (cfg_shift_en) begin
            for (int k = N_REG - 1; k > 0; k--) chain[k] <= chain[k-1];
            chain[0] <= cfg_data_in;
        end
    end
    assign cfg_data_out = chain[N_REG-1];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: shifts must follow accepted handshakes by one cycle, carrying
    // the accepted word (load) or the chain's own output (rotation).
    int          exp_rb [N_REG];
    int          rb_idx = 0;
    bit          rb_active = 0;
    bit          prev_acc_in = 0, prev_acc_out = 0;
    logic [CONFIG_L-1:0] prev_data = '0;
    int          done_cnt = 0, done_cyc = 0, shift_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_acc_in  = 0;
            prev_acc_out = 0;
        end else begin
            chk("shift_en", cfg_shift_en, prev_acc_in || prev_acc_out);
            if (prev_acc_in)
                chk("load_data_in", cfg_data_in, prev_data);
            else if (prev_acc_out)
                chk("rotate_data_in", cfg_data_in, cfg_data_out);
            if (out_valid) begin
                if (rb_active && rb_idx < N_REG)
                    chk("out_data", out_data, exp_rb[rb_idx]);
                else
                    chk("unexpected_out_valid", out_valid, 0);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (cfg_shift_en) shift_cnt++;
            prev_acc_in  = in_valid && in_ready && !abort;
            prev_acc_out = out_valid && out_ready && !abort;
            prev_data    = in_data;
            if (prev_acc_out) rb_idx++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_shift_en"}, cfg_shift_en, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_data_in"}, cfg_data_in, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_word_cnt"}, word_cnt, 0);
    endtask

    task automatic chk_chain(input string nm);
        int bad = 0;
        for (int k = 0; k < N_REG; k++)
            if (chain[k] !== CONFIG_L'(N_REG - 1 - k)) bad++;
        chk(nm, bad, 0);
    endtask

    // Load words 0,1,2,... ; abort_at >= 0 raises abort alongside the attempt
    // that would have been accept number abort_at+1.
    task automatic do_load(input bit toggle, input int abort_at,
                           output int accepted, output int first_cyc);
        int  n = 0;
        bit  hs, ab;
        accepted  = 0;
        first_cyc = -1;
        start = 1; mode = 0;
        tick;
        start = 0;
        ab = 0;
        while (accepted < N_REG && n < 3000 && !ab) begin
            in_valid = toggle ? ((n % 2) == 0) : 1'b1;
            in_data  = CONFIG_L'(accepted);
            ab       = (abort_at >= 0) && (accepted == abort_at) && in_valid;
            abort    = ab;
            @(negedge clk);
            hs = in_valid && in_ready && !abort;
            if (hs) begin
                if (first_cyc < 0) first_cyc = cyc;
                accepted++;
            end
            tick;
            n++;
        end
        in_valid = 0;
        abort    = 0;
        chk("load_budget", n < 3000, 1);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            tick;
            n++;
        end
        chk("done_seen", done_cnt, d0 + 1);
    endtask

    task automatic do_readback(input bit stall_at_10);
        int r0, d0, n, stall;
        rb_idx = 0;
        rb_active = 1;
        d0 = done_cnt;
        start = 1; mode = 1;
        tick;
        start = 0;
        r0 = cyc;
        n = 0; stall = 0;
        while (done_cnt == d0 && n < 2000) begin
            out_ready = !(stall_at_10 && rb_idx == 10 && stall < 5);
            @(negedge clk);
            if (!out_ready && out_valid) stall++;
            tick;
            n++;
        end
        out_ready = 0;
        rb_active = 0;
        chk("rb_done_seen", done_cnt, d0 + 1);
        if (stall_at_10) chk("rb_stall_cycles", stall, 5);
        else chk("rb_latency", done_cyc - r0, 810);
        chk("rb_words", rb_idx, N_REG);
        chk("rb_word_cnt", word_cnt, N_REG);
        chk_chain("rb_chain_preserved");
    endtask

    initial begin
        int acc, first, d0;
        for (int j = 0; j < N_REG; j++) exp_rb[j] = j;

        repeat (3) tick;
        chk_reset_outs("reset");
        rst = 0;
        tick;

        // burst load
        shift_cnt = 0; d0 = done_cnt;
        do_load(0, -1, acc, first);
        wait_done(20);
        chk("burst_accepts", acc, N_REG);
        chk("burst_shifts", shift_cnt, 405);
        chk("burst_done_latency", done_cyc - first, 406);
        chk("burst_word_cnt", word_cnt, 405);
        chk("burst_busy_after", busy, 0);
        chk("burst_chain_top", chain[N_REG-1], 0);
        chk("burst_chain_bottom", chain[0], 404);
        chk_chain("burst_chain");

        // bubbled load
        shift_cnt = 0;
        do_load(1, -1, acc, first);
        wait_done(20);
        chk("toggle_shifts", shift_cnt, 405);
        chk("toggle_word_cnt", word_cnt, 405);
        chk_chain("toggle_chain");

        // readbacks
        shift_cnt = 0;
        do_readback(0);
        chk("rb_shifts", shift_cnt, 405);
        do_readback(0);
        do_readback(1);

        // abort alongside an accept
        shift_cnt = 0; d0 = done_cnt;
        do_load(0, 100, acc, first);
        chk("abort_accepts", acc, 100);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_shift_en", cfg_shift_en, 0);
        chk("abort_word_cnt", word_cnt, 100);
        start = 1; mode = 0;
        tick;
        start = 0;
        chk("abort_no_done", done_cnt, d0);
        chk("abort_shifts", shift_cnt, 100);
        chk("restart_busy", busy, 1);
        chk("restart_word_cnt", word_cnt, 0);
        abort = 1;
        tick;
        abort = 0;
        chk("restart_abort_busy", busy, 0);

        // start while busy, then reset mid-load
        start = 1; mode = 0;
        tick;
        start = 0;
        in_valid = 1; in_data = 32'd7;
        repeat (3) tick;
        in_valid = 0;
        start = 1; mode = 1;
        tick;
        start = 0;
        chk("busy_start_word_cnt", word_cnt, 3);
        chk("busy_start_in_ready", in_ready, 1);
        chk("busy_start_out_valid", out_valid, 0);
        chk("busy_start_busy", busy, 1);
        in_valid = 1; in_data = 32'd9;
        tick;
        rst = 1;
        #1;
        chk_reset_outs("midrst");
        in_valid = 0;
        tick;
        rst = 0;
        tick;
        chk("post_rst_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/config_chain_loader.md
Name: config_chain_loader

Overview:
- Master for the configuration shift-register chain.
- Takes config words from the host/DMA side over a valid/ready stream and drives the chain's data_in/shift_en, one word per shift.
- Readback mode rotates the chain a full N_REG shifts and streams every word out, so the chain contents are preserved.
- Sits between the top-level host interface and the config chain, and is the only driver of shift_en.

Parameters:
- CONFIG_L, 32, width of one config word (equal to the chain word width).
- N_REG, 405, number of words in the chain (N_PE*6 + 1 + (N_PE/CONFIG_L)*10, with N_PE=64).
- CNT_L, $clog2(N_REG+1), word counter width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  single-cycle command strobe; ignored while busy=1.
- mode  input  1  sampled with start: 0=LOAD, 1=READBACK.
- abort  input  1  cancels any operation in progress.
- in_valid  input  1  write stream valid.
- in_ready  output  1  write stream ready.
- in_data  input  CONFIG_L  config word; first word accepted ends at chain position N_REG-1.
- out_valid  output  1  readback stream valid.
- out_ready  input  1  readback stream ready.
- out_data  output  CONFIG_L  readback word.
- cfg_data_in  output  CONFIG_L  to chain data_in.
- cfg_shift_en  output  1  to chain shift_en.
- cfg_data_out  input  CONFIG_L  from chain data_out (chain word N_REG-1).
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse on normal completion.
- word_cnt  output  CNT_L  words transferred in current/last operation.

Behaviour:
- Reset (async, rst=1): state IDLE. in_ready, out_valid, cfg_shift_en, busy, done = 0; cfg_data_in, out_data, word_cnt = 0.
- States: IDLE, LOAD, READ, RSHIFT, FLUSH, DONE.
- IDLE:
  - start=1 → LOAD (mode=0) or READ (mode=1) next cycle; word_cnt cleared to 0; busy=1 from that next cycle.
  - All other inputs ignored.
- LOAD:
  - in_ready=1 while word_cnt<N_REG.
  - Handshake at cycle t: cfg_data_in<=in_data and cfg_shift_en<=1 for cycle t+1; word_cnt increments.
  - No handshake at t: cfg_shift_en=0 at t+1 (bubbles allowed).
  - Handshake that makes word_cnt=N_REG: in_ready drops next cycle; state → FLUSH, where the final shift_en is high.
  - Sustained throughput is 1 word/cycle.
- FLUSH: cfg_shift_en=1 (last word) → DONE.
- READ:
  - out_valid=1, out_data=cfg_data_out (combinational pass-through), cfg_shift_en=0.
  - Handshake → RSHIFT; word_cnt increments.
- RSHIFT:
  - cfg_shift_en=1, cfg_data_in=cfg_data_out (rotate), out_valid=0.
  - Next state: READ if word_cnt<N_REG, else DONE.
  - Throughput is 1 word/2 cycles.
  - After N_REG rotations the chain content equals its pre-readback content.
  - Words emerge in order chain[N_REG-1] first, down to chain[0].
- DONE: done=1 for exactly one cycle; busy=0 in the same cycle; → IDLE. word_cnt holds its final value until the next start.
- cfg_shift_en is high only in the cycle after a LOAD handshake, in FLUSH, and in RSHIFT; never in IDLE or DONE.
- abort=1 in any non-IDLE state:
  - Next cycle: state IDLE; in_ready, out_valid, cfg_shift_en, busy = 0.
  - No done pulse; any pending shift is dropped; word_cnt holds the partial count.
  - abort takes priority over a same-cycle handshake, and that handshake is not counted.
- start and abort together in IDLE: start wins.
- start while busy: ignored, no effect on state or counters.
- in_valid in READ, and out_ready in LOAD, are ignored.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous); the chain is left partially shifted and software must reload.

Test Plan:
- Reset, then LOAD with N_REG words value i (i=0..404), in_valid held high → 405 shift_en pulses; chain word k = 404-k; done pulse 406 cycles after first accept; word_cnt=405.
- LOAD with in_valid toggling 1/0 → shift_en pattern mirrors accepts delayed by 1 cycle; chain content identical to the burst case.
- After a load, READBACK with out_ready=1 → out_data sequence 0,1,...,404; out_valid high every other cycle; done after 810 cycles; a second READBACK yields the same sequence.
- READBACK with out_ready stalled for 5 cycles at word 10 → out_data stable at 10 during the stall; no shift_en; sequence continues unchanged.
- abort after 100 load accepts (same cycle as an accept) → IDLE next cycle; word_cnt=100; no done pulse; 100 shifts total; start accepted 1 cycle later.
- start pulsed while busy, and rst asserted mid-LOAD → start has no effect; on rst all outputs 0 immediately and busy=0.
